// File: rtl/cdr_sampler_pd.sv
// Multi-lane sampler with Alexander bang-bang phase detector and a signed vote
// accumulator that emits one-cycle phase advance/retard pulses.
module cdr_sampler_pd #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned ACC_W  = 6,
  parameter int unsigned THRESH = 8,
  parameter int unsigned CNT_W  = $clog2(LANES + 1)
) (
  input  logic                    data_clock,
  input  logic                    Reset,
  input  logic                    valid_in,
  input  logic [LANES-1:0]        data_in,
  input  logic [LANES-1:0]        edge_in,
  output logic                    valid_out,
  output logic [LANES-1:0]        data_out,
  output logic [CNT_W-1:0]        up_cnt,
  output logic [CNT_W-1:0]        dn_cnt,
  output logic signed [ACC_W-1:0] acc,
  output logic                    phase_up,
  output logic                    phase_dn
);

  if (LANES < 1) begin : g_bad_lanes
    $error("cdr_sampler_pd: LANES must be at least 1");
  end
  if (THRESH < 1) begin : g_bad_thresh
    $error("cdr_sampler_pd: THRESH must be at least 1");
  end
  // The accumulator must hold THRESH-1 plus one full word of votes without wrapping.
  if (THRESH + LANES > (2 ** (ACC_W - 1)) - 1) begin : g_bad_acc_w
    $error("cdr_sampler_pd: ACC_W too narrow for THRESH + LANES");
  end

  localparam logic signed [ACC_W-1:0] THR_P = ACC_W'(THRESH);
  localparam logic signed [ACC_W-1:0] THR_N = -THR_P;

  logic                    valid_q;
  logic [LANES-1:0]        data_q;
  logic [CNT_W-1:0]        up_q, dn_q;
  logic [CNT_W-1:0]        up_d, dn_d;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] sum;
  logic                    phase_up_q, phase_dn_q;
  logic                    prev_d_q, prev_ok_q;

  logic [LANES:0]          chain;
  logic [LANES-1:0]        late_v, early_v;

  // chain[i] is Dn_1 and chain[i+1] is Dn for lane i.
  assign chain = {data_in, prev_d_q};

  always_comb begin
    late_v  = '0;
    early_v = '0;
    up_d    = '0;
    dn_d    = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      late_v[i]  = ((i != 0) || prev_ok_q) && (chain[i] ^ chain[i+1]) &&
                   (edge_in[i] == chain[i+1]);
      early_v[i] = ((i != 0) || prev_ok_q) && (chain[i] ^ chain[i+1]) &&
                   (edge_in[i] == chain[i]);
      up_d = up_d + CNT_W'(late_v[i]);
      dn_d = dn_d + CNT_W'(early_v[i]);
    end
  end

  assign sum = acc_q + $signed(ACC_W'(up_q)) - $signed(ACC_W'(dn_q));

  always_ff @(posedge data_clock or posedge Reset) begin
    if (Reset) begin
      valid_q    <= 1'b0;
      data_q     <= '0;
      up_q       <= '0;
      dn_q       <= '0;
      acc_q      <= '0;
      phase_up_q <= 1'b0;
      phase_dn_q <= 1'b0;
      prev_d_q   <= 1'b0;
      prev_ok_q  <= 1'b0;
    end else begin
      valid_q <= valid_in;
      if (valid_in) begin
        data_q    <= data_in;
        up_q      <= up_d;
        dn_q      <= dn_d;
        prev_d_q  <= data_in[LANES-1];
        prev_ok_q <= 1'b1;
      end
      phase_up_q <= 1'b0;
      phase_dn_q <= 1'b0;
      if (valid_q) begin
        if (sum >= THR_P) begin
          phase_up_q <= 1'b1;
          acc_q      <= '0;
        end else if (sum <= THR_N) begin
          phase_dn_q <= 1'b1;
          acc_q      <= '0;
        end else begin
          acc_q <= sum;
        end
      end
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign up_cnt    = up_q;
  assign dn_cnt    = dn_q;
  assign acc       = acc_q;
  assign phase_up  = phase_up_q;
  assign phase_dn  = phase_dn_q;

endmodule
